// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation select encoding
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

endpackage

// File: rtl/instruction_set_pkg.sv
// rtl/instruction_set_pkg.sv - opcode, function-field and controller state types
package instruction_set_pkg;

    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        ADDI  = 3'd1,
        LW    = 3'd2,
        SW    = 3'd3,
        BEQ   = 3'd4
    } opcode_t;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_SLT = 3'd4
    } func_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrl_state_t;

    function automatic logic uses_imm(input opcode_t op);
        return (op == ADDI) || (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - maps opcode/func to an ALU operation
module instruction_decoder
    import instruction_set_pkg::*;
    import alu_pkg::*;
(
    input  opcode_t i_opcode,
    input  func_t   i_func,
    output alu_op_t o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_opcode)
            RTYPE: begin
                case (i_func)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            // Branch compares by subtraction so the zero flag reflects equality
            BEQ:     o_alu_op = ALU_SUB;
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM with variable memory latency
module multicycle_controller
    import instruction_set_pkg::*;
    import alu_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter bit BRANCH_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  opcode_t     opcode,
    input  func_t       func,
    input  logic        zero,
    output alu_op_t     alu_op,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dm_we,
    output logic        dm_re,
    output logic        alu_src_imm,
    output logic        mem_to_reg,
    output logic        illegal,
    output ctrl_state_t state_o
);

    localparam int            CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_illegal;
    logic          w_illegal_nxt;
    logic          w_legal;
    alu_op_t       w_dec_alu_op;

    instruction_decoder u_decoder (
        .i_opcode (opcode),
        .i_func   (func),
        .o_alu_op (w_dec_alu_op)
    );

    assign w_legal = (opcode == RTYPE) || (opcode == ADDI) || (opcode == LW) ||
                     (opcode == SW) || ((opcode == BEQ) && BRANCH_EN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_illegal_nxt = r_illegal;
        case (r_state)
            FETCH: begin
                if (instr_valid) w_state_nxt = DECODE;
            end
            DECODE: begin
                if (w_legal) begin
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt   = TRAP;
                    w_illegal_nxt = 1'b1;
                end
            end
            EXEC: begin
                case (opcode)
                    RTYPE, ADDI: w_state_nxt = WB;
                    LW, SW: begin
                        w_state_nxt = MEM;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                    default:     w_state_nxt = FETCH;
                endcase
            end
            MEM: begin
                // Counter only decrements while nonzero, so it parks at 0
                if (r_cnt == '0) begin
                    w_state_nxt = (opcode == LW) ? WB : FETCH;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WB:      w_state_nxt = FETCH;
            TRAP:    w_state_nxt = TRAP;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Outputs are held low combinationally while reset is asserted
    always_comb begin
        alu_op      = ALU_ADD;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        dm_we       = 1'b0;
        dm_re       = 1'b0;
        alu_src_imm = 1'b0;
        mem_to_reg  = 1'b0;
        if (rst_n) begin
            case (r_state)
                FETCH: begin
                    ir_we = instr_valid;
                    pc_we = instr_valid;
                end
                EXEC: begin
                    alu_op      = w_dec_alu_op;
                    alu_src_imm = uses_imm(opcode);
                    pc_we       = (opcode == BEQ) && zero;
                end
                MEM: begin
                    alu_op      = w_dec_alu_op;
                    alu_src_imm = uses_imm(opcode);
                    dm_re       = (opcode == LW);
                    dm_we       = (opcode == SW) && (r_cnt == '0);
                end
                WB: begin
                    rf_we      = 1'b1;
                    mem_to_reg = (opcode == LW);
                end
                default: ;
            endcase
        end
    end

    assign illegal = r_illegal;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed vector bench for multicycle_controller
module tb_multicycle_controller;
    import instruction_set_pkg::*;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    opcode_t     opcode;
    func_t       func;
    logic        zero;

    alu_op_t     a_alu_op, n_alu_op, o_alu_op;
    logic        a_pc, a_ir, a_rf, a_dwe, a_dre, a_imm, a_m2r, a_ill;
    logic        n_pc, n_ir, n_rf, n_dwe, n_dre, n_imm, n_m2r, n_ill;
    logic        o_pc, o_ir, o_rf, o_dwe, o_dre, o_imm, o_m2r, o_ill;
    ctrl_state_t a_st, n_st, o_st;
    logic [7:0]  a_en, n_en, o_en;

    assign a_en = {a_pc, a_ir, a_rf, a_dwe, a_dre, a_imm, a_m2r, a_ill};
    assign n_en = {n_pc, n_ir, n_rf, n_dwe, n_dre, n_imm, n_m2r, n_ill};
    assign o_en = {o_pc, o_ir, o_rf, o_dwe, o_dre, o_imm, o_m2r, o_ill};

    multicycle_controller #(.MEM_LATENCY(3), .BRANCH_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .func(func), .zero(zero), .alu_op(a_alu_op), .pc_we(a_pc), .ir_we(a_ir),
        .rf_we(a_rf), .dm_we(a_dwe), .dm_re(a_dre), .alu_src_imm(a_imm),
        .mem_to_reg(a_m2r), .illegal(a_ill), .state_o(a_st)
    );

    multicycle_controller #(.MEM_LATENCY(2), .BRANCH_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .func(func), .zero(zero), .alu_op(n_alu_op), .pc_we(n_pc), .ir_we(n_ir),
        .rf_we(n_rf), .dm_we(n_dwe), .dm_re(n_dre), .alu_src_imm(n_imm),
        .mem_to_reg(n_m2r), .illegal(n_ill), .state_o(n_st)
    );

    multicycle_controller #(.MEM_LATENCY(1), .BRANCH_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
        .func(func), .zero(zero), .alu_op(o_alu_op), .pc_we(o_pc), .ir_we(o_ir),
        .rf_we(o_rf), .dm_we(o_dwe), .dm_re(o_dre), .alu_src_imm(o_imm),
        .mem_to_reg(o_m2r), .illegal(o_ill), .state_o(o_st)
    );

    typedef struct {
        logic        rstn;
        logic        iv;
        opcode_t     op;
        func_t       fn;
        logic        z;
        ctrl_state_t st;
        logic [7:0]  en;
        alu_op_t     aop;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // en bit order: pc ir rf dwe dre imm m2r ill
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_FET  = 8'b1100_0000;
    localparam logic [7:0] E_WB   = 8'b0010_0000;
    localparam logic [7:0] E_IMM  = 8'b0000_0100;
    localparam logic [7:0] E_LDM  = 8'b0000_1100;
    localparam logic [7:0] E_LWB  = 8'b0010_0010;
    localparam logic [7:0] E_STW  = 8'b0001_0100;
    localparam logic [7:0] E_BR   = 8'b1000_0000;
    localparam logic [7:0] E_TRP  = 8'b0000_0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rstn, input logic iv, input opcode_t op, input func_t fn,
                       input logic z, input ctrl_state_t st, input logic [7:0] en,
                       input alu_op_t aop);
        vec_t v;
        v.rstn = rstn; v.iv = iv; v.op = op; v.fn = fn; v.z = z;
        v.st = st; v.en = en; v.aop = aop;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rstn, input logic iv, input opcode_t op,
                         input func_t fn, input logic z);
        @(negedge clk);
        rst_n = rstn; instr_valid = iv; opcode = op; func = fn; zero = z;
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; opcode = RTYPE; func = FN_ADD; zero = 1'b0;

        // reset state with instr_valid high
        add(0, 1, RTYPE, FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        // RTYPE add, then an idle FETCH
        add(1, 1, RTYPE, FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, EXEC,   E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, WB,     E_WB,   ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        // RTYPE sub
        add(1, 1, RTYPE, FN_SUB, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, EXEC,   E_NONE, ALU_SUB);
        add(1, 0, RTYPE, FN_SUB, 0, WB,     E_WB,   ALU_ADD);
        // ADDI
        add(1, 1, ADDI,  FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, ADDI,  FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, ADDI,  FN_ADD, 0, EXEC,   E_IMM,  ALU_ADD);
        add(1, 0, ADDI,  FN_ADD, 0, WB,     E_WB,   ALU_ADD);
        // LW, MEM_LATENCY=3
        add(1, 1, LW,    FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, EXEC,   E_IMM,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, MEM,    E_LDM,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, MEM,    E_LDM,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, MEM,    E_LDM,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, WB,     E_LWB,  ALU_ADD);
        add(1, 0, LW,    FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        // SW with instr_valid held high outside FETCH
        add(1, 1, SW,    FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 1, SW,    FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 1, SW,    FN_ADD, 0, EXEC,   E_IMM,  ALU_ADD);
        add(1, 1, SW,    FN_ADD, 0, MEM,    E_IMM,  ALU_ADD);
        add(1, 1, SW,    FN_ADD, 0, MEM,    E_IMM,  ALU_ADD);
        add(1, 1, SW,    FN_ADD, 0, MEM,    E_STW,  ALU_ADD);
        add(1, 0, SW,    FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        // BEQ taken
        add(1, 1, BEQ,   FN_ADD, 1, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, BEQ,   FN_ADD, 1, DECODE, E_NONE, ALU_ADD);
        add(1, 0, BEQ,   FN_ADD, 1, EXEC,   E_BR,   ALU_SUB);
        add(1, 0, BEQ,   FN_ADD, 1, FETCH,  E_NONE, ALU_ADD);
        // BEQ not taken
        add(1, 1, BEQ,   FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, BEQ,   FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, BEQ,   FN_ADD, 0, EXEC,   E_NONE, ALU_SUB);
        add(1, 0, BEQ,   FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        // undefined opcode traps; pulses ignored; reset recovers
        add(1, 1, opcode_t'(3'd7), FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, opcode_t'(3'd7), FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, opcode_t'(3'd7), FN_ADD, 0, TRAP,   E_TRP,  ALU_ADD);
        add(1, 1, opcode_t'(3'd7), FN_ADD, 0, TRAP,   E_TRP,  ALU_ADD);
        add(0, 1, RTYPE, FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        add(1, 1, RTYPE, FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, EXEC,   E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_ADD, 0, WB,     E_WB,   ALU_ADD);
        // SW aborted by reset in its second MEM cycle
        add(1, 1, SW,    FN_ADD, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, SW,    FN_ADD, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, SW,    FN_ADD, 0, EXEC,   E_IMM,  ALU_ADD);
        add(1, 0, SW,    FN_ADD, 0, MEM,    E_IMM,  ALU_ADD);
        add(0, 0, SW,    FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        add(1, 0, SW,    FN_ADD, 0, FETCH,  E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, FETCH,  E_NONE, ALU_ADD);
        add(1, 1, RTYPE, FN_SUB, 0, FETCH,  E_FET,  ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, DECODE, E_NONE, ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, EXEC,   E_NONE, ALU_SUB);
        add(1, 0, RTYPE, FN_SUB, 0, WB,     E_WB,   ALU_ADD);
        add(1, 0, RTYPE, FN_SUB, 0, FETCH,  E_NONE, ALU_ADD);

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].iv, vecs[i].op, vecs[i].fn, vecs[i].z);
            chk($sformatf("v%0d state", i), {5'b0, a_st},     {5'b0, vecs[i].st});
            chk($sformatf("v%0d en", i),    a_en,             vecs[i].en);
            chk($sformatf("v%0d alu_op", i), {5'b0, a_alu_op}, {5'b0, vecs[i].aop});
        end

        // BRANCH_EN=0: BEQ is illegal
        drive(0, 0, BEQ, FN_ADD, 0);
        drive(1, 1, BEQ, FN_ADD, 0);
        drive(1, 0, BEQ, FN_ADD, 0);
        chk("nb beq decode", {5'b0, n_st}, {5'b0, DECODE});
        drive(1, 0, BEQ, FN_ADD, 0);
        chk("nb beq trap state", {5'b0, n_st}, {5'b0, TRAP});
        chk("nb beq trap en", n_en, E_TRP);

        // MEM_LATENCY=1 LW on dut1, MEM_LATENCY=2 LW on dut_nb
        drive(0, 0, LW, FN_ADD, 0);
        drive(1, 1, LW, FN_ADD, 0);
        drive(1, 0, LW, FN_ADD, 0);
        drive(1, 0, LW, FN_ADD, 0);
        chk("ml1 lw exec en", o_en, E_IMM);
        drive(1, 0, LW, FN_ADD, 0);
        chk("ml1 lw mem state", {5'b0, o_st}, {5'b0, MEM});
        chk("ml1 lw mem en", o_en, E_LDM);
        drive(1, 0, LW, FN_ADD, 0);
        chk("ml1 lw wb state", {5'b0, o_st}, {5'b0, WB});
        chk("ml1 lw wb en", o_en, E_LWB);
        chk("ml2 lw mem2 en", n_en, E_LDM);
        drive(1, 0, LW, FN_ADD, 0);
        chk("ml1 lw fetch", {5'b0, o_st}, {5'b0, FETCH});
        chk("ml2 lw wb en", n_en, E_LWB);

        // MEM_LATENCY=1 SW: single MEM cycle with the write
        drive(0, 0, SW, FN_ADD, 0);
        drive(1, 1, SW, FN_ADD, 0);
        drive(1, 0, SW, FN_ADD, 0);
        drive(1, 0, SW, FN_ADD, 0);
        drive(1, 0, SW, FN_ADD, 0);
        chk("ml1 sw mem state", {5'b0, o_st}, {5'b0, MEM});
        chk("ml1 sw mem en", o_en, E_STW);
        chk("ml2 sw mem1 en", n_en, E_IMM);
        drive(1, 0, SW, FN_ADD, 0);
        chk("ml1 sw fetch state", {5'b0, o_st}, {5'b0, FETCH});
        chk("ml1 sw fetch en", o_en, E_NONE);
        chk("ml2 sw mem2 en", n_en, E_STW);
        drive(1, 0, SW, FN_ADD, 0);
        chk("ml2 sw fetch", {5'b0, n_st}, {5'b0, FETCH});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
